ad9361_cfg_seq: RTL and testbench

//  Table-driven configuration sequencer and bus owner for the AD9361 SPI master.
//  On start it walks a register table (WRITE / WAIT / POLL / END entries) and issues SPI transactions.

---
 rtl/ad9361_cfg_seq_if.sv | 41 ++++
 rtl/ad9361_cfg_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_ad9361_cfg_seq.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad9361_cfg_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : ad9361_cfg_seq_if
// Purpose  : Bus bundle between the configuration sequencer and the
//            ad9361_spi master (Avalon-style strobe / waitrequest handshake).
// Signals  : spi_read   - read strobe, held until spi_wait is sampled low
//            spi_write  - write strobe, held until spi_wait is sampled low
//            spi_addr   - 10-bit AD9361 register address
//            spi_wdata  - write data
//            spi_rdata  - read data, valid in the cycle spi_wait is low
//            spi_wait   - waitrequest; low for one cycle completes a transfer
// Modports : master (sequencer side), slave (SPI engine side)
// Revision : 1.0 - initial release
// ============================================================================
interface ad9361_cfg_seq_if;
  logic       spi_read;
  logic       spi_write;
  logic [9:0] spi_addr;
  logic [7:0] spi_wdata;
  logic [7:0] spi_rdata;
  logic       spi_wait;

  modport master (
    output spi_read,
    output spi_write,
    output spi_addr,
    output spi_wdata,
    input  spi_rdata,
    input  spi_wait
  );

  modport slave (
    input  spi_read,
    input  spi_write,
    input  spi_addr,
    input  spi_wdata,
    output spi_rdata,
    output spi_wait
  );
endinterface
`default_nettype wire

// File: rtl/ad9361_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : ad9361_cfg_seq
// Purpose  : Table-driven configuration sequencer and bus owner for the
//            AD9361 SPI master. On start it walks a register table made of
//            WRITE / WAIT / POLL / END entries and issues SPI transactions.
//            When idle, a runtime host port shares the same SPI master.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            start             - pulse, run table from entry 0
//            busy/done/error   - sequence status (done is a 1-cycle pulse,
//                                error is sticky until the next start)
//            err_idx           - table index of the failing entry
//            tbl_addr/tbl_data - table ROM, 1-cycle synchronous read
//                                word: [27:26] op, [25:16] addr,
//                                [15:8] mask, [7:0] data
//            host_*            - host request/ack transaction port
//            spi               - master side of the SPI bus bundle
// Revision : 1.0 - initial release
// ============================================================================
module ad9361_cfg_seq #(
  parameter int TBL_AW     = 8,
  parameter int DELAY_UNIT = 1000,
  parameter int POLL_LIMIT = 255,
  parameter int POLL_GAP   = 64
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [TBL_AW-1:0]      err_idx,
  output logic [TBL_AW-1:0]      tbl_addr,
  input  wire logic [27:0]       tbl_data,
  input  wire logic              host_req,
  input  wire logic              host_wr,
  input  wire logic [9:0]        host_addr,
  input  wire logic [7:0]        host_wdata,
  output logic [7:0]             host_rdata,
  output logic                   host_ack,
  ad9361_cfg_seq_if.master       spi
);

  localparam logic [1:0] C_OP_WRITE = 2'd0;
  localparam logic [1:0] C_OP_WAIT  = 2'd1;
  localparam logic [1:0] C_OP_POLL  = 2'd2;
  localparam logic [1:0] C_OP_END   = 2'd3;

  // {mask,data} is a 16-bit count scaled by DELAY_UNIT
  localparam int C_DLY_W = 16 + $clog2(DELAY_UNIT + 1);
  localparam int C_PC_W  = $clog2(POLL_LIMIT + 1);
  localparam int C_GAP_W = $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_XFER   = 4'd3,
    ST_DELAY  = 4'd4,
    ST_GAP    = 4'd5,
    ST_DONE   = 4'd6,
    ST_ERROR  = 4'd7,
    ST_HOST   = 4'd8
  } state_t;

  state_t               r_state;
  logic [TBL_AW-1:0]    r_idx;
  logic                 r_is_poll;
  logic [7:0]           r_mask;
  logic [7:0]           r_data;
  logic [C_DLY_W-1:0]   r_dly_cnt;
  logic [C_PC_W-1:0]    r_poll_cnt;
  logic [C_GAP_W-1:0]   r_gap_cnt;

  logic [C_DLY_W-1:0]   w_delay_total;
  logic                 w_spi_cpl;
  logic                 w_poll_hit;
  logic                 w_idx_last;
  logic [TBL_AW-1:0]    w_idx_next;

  assign w_delay_total = C_DLY_W'(tbl_data[15:0]) * C_DLY_W'(DELAY_UNIT);
  // Transfer completes on the edge where the strobe is up and waitrequest is low
  assign w_spi_cpl     = (spi.spi_read | spi.spi_write) & ~spi.spi_wait;
  assign w_poll_hit    = (((spi.spi_rdata ^ r_data) & r_mask) == 8'd0);
  // Advancing past the last table slot without an END is a table overrun
  assign w_idx_last    = (r_idx == {TBL_AW{1'b1}});
  assign w_idx_next    = r_idx + TBL_AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_is_poll     <= 1'b0;
      r_mask        <= '0;
      r_data        <= '0;
      r_dly_cnt     <= '0;
      r_poll_cnt    <= '0;
      r_gap_cnt     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_idx       <= '0;
      tbl_addr      <= '0;
      host_rdata    <= '0;
      host_ack      <= 1'b0;
      spi.spi_read  <= 1'b0;
      spi.spi_write <= 1'b0;
      spi.spi_addr  <= '0;
      spi.spi_wdata <= '0;
    end else begin
      done     <= 1'b0;
      host_ack <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx    <= '0;
            tbl_addr <= '0;
            error    <= 1'b0;
            busy     <= 1'b1;
            r_state  <= ST_FETCH;
          end else if (host_req && !host_ack) begin
            // host_ack is still high in the cycle after a host transfer while
            // the requester drops host_req; don't treat that as a new request
            spi.spi_write <= host_wr;
            spi.spi_read  <= ~host_wr;
            spi.spi_addr  <= host_addr;
            spi.spi_wdata <= host_wdata;
            r_state       <= ST_HOST;
          end
        end

        ST_FETCH: begin
          // tbl_addr already holds r_idx; ROM word is valid next cycle
          r_state <= ST_DECODE;
        end

        ST_DECODE: begin
          r_mask    <= tbl_data[15:8];
          r_data    <= tbl_data[7:0];
          r_is_poll <= (tbl_data[27:26] == C_OP_POLL);
          case (tbl_data[27:26])
            C_OP_WRITE: begin
              spi.spi_write <= 1'b1;
              spi.spi_addr  <= tbl_data[25:16];
              spi.spi_wdata <= tbl_data[7:0];
              r_state       <= ST_XFER;
            end
            C_OP_WAIT: begin
              // zero count still spends one cycle in DELAY
              r_dly_cnt <= (w_delay_total == '0) ? '0
                                                 : w_delay_total - C_DLY_W'(1);
              r_state   <= ST_DELAY;
            end
            C_OP_POLL: begin
              spi.spi_read <= 1'b1;
              spi.spi_addr <= tbl_data[25:16];
              r_poll_cnt   <= C_PC_W'(1);
              r_state      <= ST_XFER;
            end
            default: begin
              r_state <= ST_DONE;
            end
          endcase
        end

        ST_XFER: begin
          if (w_spi_cpl) begin
            spi.spi_read  <= 1'b0;
            spi.spi_write <= 1'b0;
            if (!r_is_poll || w_poll_hit) begin
              if (w_idx_last) begin
                r_state <= ST_ERROR;
              end else begin
                r_idx    <= w_idx_next;
                tbl_addr <= w_idx_next;
                r_state  <= ST_FETCH;
              end
            end else if (r_poll_cnt == C_PC_W'(POLL_LIMIT)) begin
              r_state <= ST_ERROR;
            end else begin
              r_gap_cnt <= C_GAP_W'(POLL_GAP - 1);
              r_state   <= ST_GAP;
            end
          end
        end

        ST_DELAY: begin
          if (r_dly_cnt == '0) begin
            if (w_idx_last) begin
              r_state <= ST_ERROR;
            end else begin
              r_idx    <= w_idx_next;
              tbl_addr <= w_idx_next;
              r_state  <= ST_FETCH;
            end
          end else begin
            r_dly_cnt <= r_dly_cnt - C_DLY_W'(1);
          end
        end

        ST_GAP: begin
          // address is unchanged from the previous read of this entry
          if (r_gap_cnt == '0) begin
            spi.spi_read <= 1'b1;
            r_poll_cnt   <= r_poll_cnt + C_PC_W'(1);
            r_state      <= ST_XFER;
          end else begin
            r_gap_cnt <= r_gap_cnt - C_GAP_W'(1);
          end
        end

        ST_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end

        ST_ERROR: begin
          error   <= 1'b1;
          err_idx <= r_idx;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end

        ST_HOST: begin
          if (w_spi_cpl) begin
            if (spi.spi_read) begin
              host_rdata <= spi.spi_rdata;
            end
            spi.spi_read  <= 1'b0;
            spi.spi_write <= 1'b0;
            host_ack      <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad9361_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad9361_cfg_seq
// Purpose  : Directed self-checking bench for ad9361_cfg_seq. A table ROM and
//            an SPI slave model with fixed latency surround the sequencer;
//            expected SPI transfers are queued as each test is set up and
//            matched in order as the slave model completes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad9361_cfg_seq;

  localparam int TBL_AW     = 4;
  localparam int DELAY_UNIT = 10;
  localparam int POLL_LIMIT = 4;
  localparam int POLL_GAP   = 8;
  localparam int SPI_LAT    = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, error, host_ack;
  logic [TBL_AW-1:0] err_idx, tbl_addr;
  logic [27:0]       tbl_data;
  logic              host_req = 1'b0;
  logic              host_wr = 1'b0;
  logic [9:0]        host_addr = '0;
  logic [7:0]        host_wdata = '0;
  logic [7:0]        host_rdata;

  ad9361_cfg_seq_if spi_if ();

  ad9361_cfg_seq #(
    .TBL_AW     (TBL_AW),
    .DELAY_UNIT (DELAY_UNIT),
    .POLL_LIMIT (POLL_LIMIT),
    .POLL_GAP   (POLL_GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_idx    (err_idx),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .host_req   (host_req),
    .host_wr    (host_wr),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .spi        (spi_if)
  );

  always #5 clk = ~clk;

  // ---------------- table ROM ----------------
  logic [27:0] rom [0:(1<<TBL_AW)-1];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [18:0] exp_q [$];   // {is_write, addr, wdata-or-0}
  logic [7:0]  rd_q  [$];   // values the slave returns for reads
  int          gap_q [$];   // idle cycles before each transfer start
  int          cpl_cyc = 0;
  int          lat = 0;
  logic        prev_stb = 1'b0;
  logic        prev_cpl = 1'b0;
  logic        stb;
  logic [18:0] got;
  int          done_cnt = 0, done_cyc = 0;
  int          ack_cyc = 0;
  int          gap;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [27:0] ent(input logic [1:0] op, input logic [9:0] a,
                                      input logic [7:0] m, input logic [7:0] d);
    return {op, a, m, d};
  endfunction

  // ---------------- SPI slave model + monitor (negedge) ----------------
  always @(negedge clk) begin
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (host_ack) ack_cyc = cyc;
    if (!rst_n) begin
      spi_if.spi_wait  = 1'b1;
      spi_if.spi_rdata = 8'h00;
      lat      = 0;
      prev_stb = 1'b0;
      prev_cpl = 1'b0;
    end else begin
      stb = spi_if.spi_read | spi_if.spi_write;
      if (stb && (!prev_stb || prev_cpl)) begin
        gap = cyc - cpl_cyc - 1;
        gap_q.push_back(gap);
        check("idle_after_cpl", 32'(gap >= 1), 1);
        check("strobe_exclusive", 32'(spi_if.spi_read & spi_if.spi_write), 0);
      end
      prev_cpl = 1'b0;
      if (stb) begin
        lat++;
        if (lat == SPI_LAT) begin
          lat = 0;
          spi_if.spi_wait = 1'b0;
          if (spi_if.spi_read)
            spi_if.spi_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
          got = {spi_if.spi_write, spi_if.spi_addr,
                 spi_if.spi_write ? spi_if.spi_wdata : 8'h00};
          check("xfer_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("xfer_order", 32'(got), 32'(exp_q.pop_front()));
          cpl_cyc  = cyc;
          prev_cpl = 1'b1;
        end else begin
          spi_if.spi_wait = 1'b1;
        end
      end else begin
        lat = 0;
        spi_if.spi_wait = 1'b1;
      end
      prev_stb = stb;
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    check(tag, 32'(busy), 0);
    @(negedge clk);
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!host_ack && n < 2000) begin @(negedge clk); n++; end
    check(tag, 32'(host_ack), 1);
    host_req = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [18:0] wr(input logic [9:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic logic [18:0] rd(input logic [9:0] a);
    return {1'b0, a, 8'h00};
  endfunction

  int d0;

  initial begin
    for (int i = 0; i < (1<<TBL_AW); i++) rom[i] = ent(2'd3, 10'h0, 8'h0, 8'h0);

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_tbl_addr", 32'(tbl_addr), 0);
    check("rst_strobes", 32'({spi_if.spi_read, spi_if.spi_write}), 0);
    check("rst_host", 32'({host_ack, host_rdata}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ---- T1: two writes then END ----
    rom[0] = ent(2'd0, 10'h3DF, 8'h00, 8'h01);
    rom[1] = ent(2'd0, 10'h2A6, 8'h00, 8'h0E);
    rom[2] = ent(2'd3, 10'h000, 8'h00, 8'h00);
    exp_q.push_back(wr(10'h3DF, 8'h01));
    exp_q.push_back(wr(10'h2A6, 8'h0E));
    d0 = done_cnt;
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    wait_idle("t1_timeout");
    check("t1_done_pulses", 32'(done_cnt - d0), 1);
    check("t1_error", 32'(error), 0);
    check("t1_all_xfers", 32'(exp_q.size()), 0);

    // ---- T2: POLL succeeds on third read ----
    rom[0] = ent(2'd0, 10'h010, 8'h00, 8'h11);
    rom[1] = ent(2'd2, 10'h247, 8'h02, 8'h02);
    rom[2] = ent(2'd0, 10'h011, 8'h00, 8'h22);
    rom[3] = ent(2'd3, 10'h000, 8'h00, 8'h00);
    exp_q.push_back(wr(10'h010, 8'h11));
    repeat (3) exp_q.push_back(rd(10'h247));
    exp_q.push_back(wr(10'h011, 8'h22));
    rd_q.push_back(8'h00); rd_q.push_back(8'h00); rd_q.push_back(8'h02);
    gap_q.delete();
    d0 = done_cnt;
    pulse_start();
    wait_idle("t2_timeout");
    check("t2_all_xfers", 32'(exp_q.size()), 0);
    check("t2_reads_used", 32'(rd_q.size()), 0);
    check("t2_xfer_count", 32'(gap_q.size()), 5);
    check("t2_gap_read2", 32'(gap_q[2] >= POLL_GAP), 1);
    check("t2_gap_read3", 32'(gap_q[3] >= POLL_GAP), 1);
    check("t2_done_pulses", 32'(done_cnt - d0), 1);
    check("t2_error", 32'(error), 0);

    // ---- T3: POLL timeout at entry 1 ----
    rom[0] = ent(2'd0, 10'h020, 8'h00, 8'h33);
    rom[1] = ent(2'd2, 10'h100, 8'h01, 8'h01);
    rom[2] = ent(2'd3, 10'h000, 8'h00, 8'h00);
    exp_q.push_back(wr(10'h020, 8'h33));
    repeat (POLL_LIMIT) exp_q.push_back(rd(10'h100));
    d0 = done_cnt;
    pulse_start();
    wait_idle("t3_timeout");
    check("t3_all_reads", 32'(exp_q.size()), 0);
    check("t3_error", 32'(error), 1);
    check("t3_err_idx", 32'(err_idx), 1);
    check("t3_no_done", 32'(done_cnt - d0), 0);

    // ---- T4/T5: WAIT 3 units, host read held off, mid-run start ignored ----
    rom[0] = ent(2'd0, 10'h050, 8'h00, 8'h5A);
    rom[1] = ent(2'd1, 10'h000, 8'h00, 8'h03);
    rom[2] = ent(2'd0, 10'h051, 8'h00, 8'hA5);
    rom[3] = ent(2'd3, 10'h000, 8'h00, 8'h00);
    exp_q.push_back(wr(10'h050, 8'h5A));
    exp_q.push_back(wr(10'h051, 8'hA5));
    exp_q.push_back(rd(10'h037));
    rd_q.push_back(8'h3C);
    gap_q.delete();
    d0 = done_cnt;
    pulse_start();
    check("t5_error_cleared", 32'(error), 0);
    repeat (4) @(negedge clk);
    host_req = 1'b1; host_wr = 1'b0; host_addr = 10'h037;
    repeat (10) @(negedge clk);
    pulse_start();
    wait_ack("t5_ack_timeout");
    check("t5_ack_after_done", 32'(ack_cyc > done_cyc), 1);
    check("t5_done_pulses", 32'(done_cnt - d0), 1);
    check("t5_host_rdata", 32'(host_rdata), 32'h3C);
    check("t5_all_xfers", 32'(exp_q.size()), 0);
    // 30-cycle wait (+-2) plus two FETCH/DECODE pairs between the writes
    check("t4_wait_window", 32'(gap_q[1] >= 32 && gap_q[1] <= 36), 1);

    // host write leaves host_rdata alone
    exp_q.push_back(wr(10'h0AA, 8'h5C));
    host_req = 1'b1; host_wr = 1'b1; host_addr = 10'h0AA; host_wdata = 8'h5C;
    wait_ack("hw_ack_timeout");
    check("hw_rdata_kept", 32'(host_rdata), 32'h3C);
    check("hw_all_xfers", 32'(exp_q.size()), 0);

    // ---- table overrun: no END in any slot ----
    for (int i = 0; i < (1<<TBL_AW); i++) rom[i] = ent(2'd1, 10'h0, 8'h0, 8'h0);
    d0 = done_cnt;
    pulse_start();
    wait_idle("ovf_timeout");
    check("ovf_error", 32'(error), 1);
    check("ovf_err_idx", 32'(err_idx), (1<<TBL_AW) - 1);
    check("ovf_no_done", 32'(done_cnt - d0), 0);

    // ---- T6: reset during SPI write ----
    rom[0] = ent(2'd0, 10'h3DF, 8'h00, 8'h01);
    rom[1] = ent(2'd0, 10'h2A6, 8'h00, 8'h0E);
    rom[2] = ent(2'd3, 10'h000, 8'h00, 8'h00);
    exp_q.push_back(wr(10'h3DF, 8'h01));
    pulse_start();
    begin
      int n = 0;
      while (!spi_if.spi_write && n < 50) begin @(negedge clk); n++; end
      check("t6_write_seen", 32'(spi_if.spi_write), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_strobes_drop", 32'({spi_if.spi_read, spi_if.spi_write}), 0);
    check("t6_busy_reset", 32'(busy), 0);
    exp_q.delete();
    rd_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_busy_after", 32'(busy), 0);
    check("t6_tbl_addr", 32'(tbl_addr), 0);
    exp_q.push_back(wr(10'h3DF, 8'h01));
    exp_q.push_back(wr(10'h2A6, 8'h0E));
    d0 = done_cnt;
    pulse_start();
    wait_idle("t6_timeout");
    check("t6_rerun_done", 32'(done_cnt - d0), 1);
    check("t6_all_xfers", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
